demux_frame_ctrl: RTL and testbench

- Frame-level controller for the switch's 1-to-4 egress demux.
- Accepts one ingress beat stream with a per-frame destination port, drives the demux select, and holds it for the whole frame.
- Converts ingress valid/ready into per-port valid/ready and drops frames aimed at disabled ports.
- Sits between the ingress frame buffer and the egress demux.

---
 rtl/demux_frame_ctrl.sv | 154 +++++++++++++++
 tb/tb_demux_frame_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_frame_ctrl.sv
// Frame controller for the 1-to-4 egress demux: holds sel per frame,
// drops frames to disabled ports, truncates oversize frames.
// Optional statistics counters: define DEMUX_FRAME_CTRL_STATS_EN.
module demux_frame_ctrl #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 1518,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       in_dest,
  input  logic [3:0]       port_en,
  input  logic [3:0]       out_ready,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_valid,
  output logic             out_last,
  output logic             oversize_err
`ifdef DEMUX_FRAME_CTRL_STATS_EN
  ,
  output logic [4*CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0]   drop_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

  state_t           state_q;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic xfer;
  logic at_max;
  logic trunc;

  assign xfer   = in_valid & in_ready;
  assign at_max = (cnt_q == LAST_CNT);
  assign trunc  = (state_q == FWD) & xfer & at_max & ~in_last;

  assign sel          = sel_q;
  assign oversize_err = err_q;
  assign out_data     = in_data;

  // Handshake steering: pass-through in FWD, sink in DROP, stall in IDLE.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 4'b0000;
    out_last  = 1'b0;
    unique case (state_q)
      FWD: begin
        in_ready         = out_ready[sel_q];
        out_valid[sel_q] = in_valid;
        out_last         = in_last | at_max;
      end
      DROP: begin
        in_ready = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Frame FSM; the last beat allowed is counted as MAX_BEATS-1 from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= trunc;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sel_q   <= in_dest;
            cnt_q   <= '0;
            state_q <= port_en[in_dest] ? FWD : DROP;
          end
        end
        FWD: begin
          if (xfer) begin
            if (!at_max) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
            if (in_last) begin
              state_q <= IDLE;
            end else if (at_max) begin
              state_q <= DROP;
            end
          end
        end
        DROP: begin
          if (xfer && in_last) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef DEMUX_FRAME_CTRL_STATS_EN
  logic [CNT_W-1:0] fc_q [4];
  logic [CNT_W-1:0] dc_q;
  logic             fwd_end;
  logic             idle_drop;

  assign fwd_end   = (state_q == FWD) & xfer & out_last;
  assign idle_drop = (state_q == IDLE) & in_valid & ~port_en[in_dest];
  assign drop_cnt  = dc_q;

  // Flatten per-port frame counters onto the output bus.
  always_comb begin
    frame_cnt = '0;
    for (int p = 0; p < 4; p++) begin
      frame_cnt[p*CNT_W +: CNT_W] = fc_q[p];
    end
  end

  // Saturating frame and drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 4; p++) begin
        fc_q[p] <= '0;
      end
      dc_q <= '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (fwd_end && sel_q == 2'(p) && fc_q[p] != '1) begin
          fc_q[p] <= fc_q[p] + CNT_W'(1);
        end
      end
      if (idle_drop && dc_q != '1) begin
        dc_q <= dc_q + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux_frame_ctrl.sv
// Testbench for demux_frame_ctrl (MAX_BEATS=4): frame table plus
// hand-written stall and reset sequences, checked by a beat scoreboard.
module tb_demux_frame_ctrl;

  localparam int W  = 8;
  localparam int MB = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic [1:0]    in_dest;
  logic [3:0]    port_en;
  logic [3:0]    out_ready;
  logic [1:0]    sel;
  logic [W-1:0]  out_data;
  logic [3:0]    out_valid;
  logic          out_last;
  logic          oversize_err;
`ifdef DEMUX_FRAME_CTRL_STATS_EN
  logic [4*CW-1:0] frame_cnt;
  logic [CW-1:0]   drop_cnt;
`endif

  demux_frame_ctrl #(
    .WIDTH(W),
    .MAX_BEATS(MB),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .in_dest(in_dest),
    .port_en(port_en),
    .out_ready(out_ready),
    .sel(sel),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_last(out_last),
    .oversize_err(oversize_err)
`ifdef DEMUX_FRAME_CTRL_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] dest;
    int         nbeats;
    logic [3:0] pen;
    int         exp_out;
    int         exp_err;
    int         exp_cyc;
  } vec_t;

  typedef struct {
    logic [1:0]   port;
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int pops = 0;
  int err_seen = 0;
  int exp_fc[4] = '{0, 0, 0, 0};
  int exp_dc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [1:0] port, input int n,
                            input int base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.port = port;
      b.data = W'(base + i);
      b.last = (i == n - 1);
      sb.push_back(b);
    end
  endtask

  // Monitor: pops the scoreboard on every egress transfer.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (oversize_err === 1'b1) err_seen++;
      if (out_valid !== 4'b0000) begin
        chk("onehot", $countones(out_valid), 1);
        if ((out_valid & out_ready) !== 4'b0000) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            beat_t e;
            e = sb.pop_front();
            pops++;
            chk("beat_port", int'(sel), int'(e.port));
            chk("beat_valid", int'(out_valid), 1 << e.port);
            chk("beat_data", int'(out_data), int'(e.data));
            chk("beat_last", int'(out_last), int'(e.last));
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [1:0] dest, input int n,
                            input logic [3:0] pen, input int base,
                            output int cycles);
    bit ok;
    int g;
    cycles = 0;
    port_en = pen;
    in_dest = dest;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = W'(base + i);
      in_last = (i == n - 1);
      if (i > 0) begin
        in_dest = ~dest;
        port_en = ~pen;
      end
      g = 0;
      do begin
        @(negedge clk);
        ok = (in_ready === 1'b1);
        @(posedge clk);
        #1;
        cycles++;
        g++;
      end while (!ok && g < 50);
      if (!ok) begin
        chk("beat_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

`ifdef DEMUX_FRAME_CTRL_STATS_EN
  task automatic chk_stats();
    for (int p = 0; p < 4; p++) begin
      chk("frame_cnt", int'(frame_cnt[p*CW +: CW]), exp_fc[p]);
    end
    chk("drop_cnt", int'(drop_cnt), exp_dc);
  endtask
`endif

  vec_t vecs[9];

  initial begin
    int cyc;
    int e0;
    int p0;
    int g;

    vecs[0] = '{2'd2, 3, 4'hF, 3, 0, 4};
    vecs[1] = '{2'd1, 4, 4'b1101, 0, 0, 5};
    vecs[2] = '{2'd0, 6, 4'hF, 4, 1, 7};
    vecs[3] = '{2'd0, 2, 4'hF, 2, 0, 3};
    vecs[4] = '{2'd3, 4, 4'hF, 4, 0, 5};
    vecs[5] = '{2'd0, 1, 4'hF, 1, 0, 2};
    vecs[6] = '{2'd1, 1, 4'hF, 1, 0, 2};
    vecs[7] = '{2'd2, 1, 4'hF, 1, 0, 2};
    vecs[8] = '{2'd3, 1, 4'hF, 1, 0, 2};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    in_dest = 2'd0;
    port_en = 4'hF;
    out_ready = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_err", int'(oversize_err), 0);
`ifdef DEMUX_FRAME_CTRL_STATS_EN
    chk_stats();
`endif
    @(posedge clk);
    #1;

    for (int v = 0; v < 9; v++) begin
      e0 = err_seen;
      push_frame(vecs[v].dest, vecs[v].exp_out, v * 16);
      if (vecs[v].exp_out > 0) exp_fc[vecs[v].dest]++;
      else exp_dc++;
      send_frame(vecs[v].dest, vecs[v].nbeats, vecs[v].pen,
                 v * 16, cyc);
      chk("frame_cycles", cyc, vecs[v].exp_cyc);
      chk("sel_hold", int'(sel), int'(vecs[v].dest));
      chk("oversize_pulses", err_seen - e0, vecs[v].exp_err);
`ifdef DEMUX_FRAME_CTRL_STATS_EN
      chk_stats();
`endif
    end
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drain_table", sb.size(), 0);

    // Stall port 3 for five cycles after its first beat.
    push_frame(2'd3, 4, 'hA0);
    exp_fc[3]++;
    p0 = pops;
    fork
      send_frame(2'd3, 4, 4'hF, 'hA0, cyc);
      begin
        g = 0;
        while (pops < p0 + 1 && g < 50) begin
          @(posedge clk);
          g++;
        end
        #1;
        out_ready = 4'b0111;
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", int'(in_ready), 0);
          chk("stall_valid", int'(out_valid), 4'b1000);
        end
        @(posedge clk);
        #1;
        out_ready = 4'hF;
      end
    join
    chk("stall_cycles", cyc, 10);
    chk("stall_pops", pops - p0, 4);
`ifdef DEMUX_FRAME_CTRL_STATS_EN
    chk_stats();
`endif
    @(posedge clk);
    #1;

    // Reset on the second beat of a frame to port 2.
    port_en = 4'hF;
    in_dest = 2'd2;
    in_valid = 1'b1;
    in_data = 'hC0;
    in_last = 1'b0;
    @(posedge clk);
    #1;
    push_frame(2'd2, 1, 'hC0);
    sb[$].last = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_sel", int'(sel), 2);
    in_data = 'hC1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_sel", int'(sel), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_ready", int'(in_ready), 0);
    chk("mid_rst_err", int'(oversize_err), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drain_final", sb.size(), 0);
    chk("total_pulses", err_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
